// File: rtl/wb_pkg.sv
// Shared definitions for the single-master Wishbone interconnect:
// slave indices, default address map and outstanding-counter width.
package wb_pkg;

    typedef enum logic [1:0] {
        SLV_BOOTROM = 2'd0,
        SLV_RAM     = 2'd1,
        SLV_IO      = 2'd2,
        SLV_NONE    = 2'd3
    } slv_t;

    localparam int unsigned NUM_SLV = 3;

    localparam logic [31:0] DEF_S0_BASE = 32'hb000_0000;
    localparam logic [31:0] DEF_S0_MASK = 32'hffff_8000;
    localparam logic [31:0] DEF_S1_BASE = 32'hb000_8000;
    localparam logic [31:0] DEF_S1_MASK = 32'hffff_8000;
    localparam logic [31:0] DEF_S2_BASE = 32'hc000_0000;
    localparam logic [31:0] DEF_S2_MASK = 32'hffff_f000;

    localparam int unsigned OUTST_W = 2;

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational address decoder: prioritised one-hot slave select,
// target index and in-slave offset (decode-mask bits cleared).
module wb_addr_decode
    import wb_pkg::*;
#(
    parameter logic [31:0] S0_BASE = DEF_S0_BASE,
    parameter logic [31:0] S0_MASK = DEF_S0_MASK,
    parameter logic [31:0] S1_BASE = DEF_S1_BASE,
    parameter logic [31:0] S1_MASK = DEF_S1_MASK,
    parameter logic [31:0] S2_BASE = DEF_S2_BASE,
    parameter logic [31:0] S2_MASK = DEF_S2_MASK
) (
    input  logic [31:0] addr,
    output logic [2:0]  sel,
    output slv_t        target,
    output logic [31:0] offset
);

    logic [NUM_SLV-1:0] hit;

    always_comb begin
        hit[0] = ((addr & S0_MASK) == S0_BASE);
        hit[1] = ((addr & S1_MASK) == S1_BASE);
        hit[2] = ((addr & S2_MASK) == S2_BASE);

        sel    = '0;
        target = SLV_NONE;
        offset = addr;
        // Overlapping windows resolve towards the lower slave index.
        if (hit[0]) begin
            sel    = 3'b001;
            target = SLV_BOOTROM;
            offset = addr & ~S0_MASK;
        end else if (hit[1]) begin
            sel    = 3'b010;
            target = SLV_RAM;
            offset = addr & ~S1_MASK;
        end else if (hit[2]) begin
            sel    = 3'b100;
            target = SLV_IO;
            offset = addr & ~S2_MASK;
        end
    end

endmodule

// File: rtl/wb_interconnect.sv
// Single-master, three-slave pipelined Wishbone router with owner tracking,
// unmapped-address and timeout bus errors.
module wb_interconnect
    import wb_pkg::*;
#(
    parameter logic [31:0] S0_BASE         = DEF_S0_BASE,
    parameter logic [31:0] S0_MASK         = DEF_S0_MASK,
    parameter logic [31:0] S1_BASE         = DEF_S1_BASE,
    parameter logic [31:0] S1_MASK         = DEF_S1_MASK,
    parameter logic [31:0] S2_BASE         = DEF_S2_BASE,
    parameter logic [31:0] S2_MASK         = DEF_S2_MASK,
    parameter int unsigned TIMEOUT         = 16,
    parameter int unsigned MAX_OUTSTANDING = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic        o_wb_stall,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic        o_exception,
    output logic [31:0] o_s_addr,
    output logic [31:0] o_s_data,
    output logic        o_s_we,
    output logic [2:0]  o_s_cyc,
    output logic [2:0]  o_s_stb,
    input  logic [2:0]  i_s_stall,
    input  logic [2:0]  i_s_ack,
    input  logic [95:0] i_s_data
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);

    slv_t               owner_q, owner_d, target;
    logic [OUTST_W-1:0] outst_q, outst_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               err_q, err_d;

    logic [2:0]  sel;
    logic [31:0] offset;
    logic [31:0] owner_rdata;
    logic        owner_ack_raw, owner_stall, target_stall;
    logic        local_stall, stall, owner_ack;
    logic        accept_map, accept_unmap, timeout_hit;

    wb_addr_decode #(
        .S0_BASE (S0_BASE),
        .S0_MASK (S0_MASK),
        .S1_BASE (S1_BASE),
        .S1_MASK (S1_MASK),
        .S2_BASE (S2_BASE),
        .S2_MASK (S2_MASK)
    ) u_decode (
        .addr   (i_addr),
        .sel    (sel),
        .target (target),
        .offset (offset)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= SLV_NONE;
            outst_q <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            owner_q <= owner_d;
            outst_q <= outst_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        owner_d = owner_q;
        outst_d = outst_q;
        timer_d = timer_q;
        err_d   = 1'b0;
        if (!i_wb_cyc) begin
            owner_d = SLV_NONE;
            outst_d = '0;
            timer_d = '0;
        end else if (timeout_hit) begin
            owner_d = SLV_NONE;
            outst_d = '0;
            timer_d = '0;
            err_d   = 1'b1;
        end else begin
            err_d   = accept_unmap;
            timer_d = (outst_q == '0 || owner_ack) ? '0 : timer_q + 1'b1;
            if (accept_map && !owner_ack) begin
                outst_d = outst_q + 1'b1;
                owner_d = target;
            end else if (!accept_map && owner_ack) begin
                outst_d = outst_q - 1'b1;
                if (outst_q == OUTST_W'(1))
                    owner_d = SLV_NONE;
            end else if (accept_map && owner_ack) begin
                owner_d = target;
            end
        end
    end

    always_comb begin
        owner_ack_raw = 1'b0;
        owner_stall   = 1'b0;
        owner_rdata   = '0;
        case (owner_q)
            SLV_BOOTROM: begin
                owner_ack_raw = i_s_ack[0];
                owner_stall   = i_s_stall[0];
                owner_rdata   = i_s_data[31:0];
            end
            SLV_RAM: begin
                owner_ack_raw = i_s_ack[1];
                owner_stall   = i_s_stall[1];
                owner_rdata   = i_s_data[63:32];
            end
            SLV_IO: begin
                owner_ack_raw = i_s_ack[2];
                owner_stall   = i_s_stall[2];
                owner_rdata   = i_s_data[95:64];
            end
            default: ;
        endcase

        // With nothing outstanding there is no owner, so the decoded slave's
        // own stall must hold the master off instead.
        case (target)
            SLV_BOOTROM: target_stall = i_s_stall[0];
            SLV_RAM:     target_stall = i_s_stall[1];
            SLV_IO:      target_stall = i_s_stall[2];
            default:     target_stall = 1'b0;
        endcase

        local_stall = (outst_q != '0 && target != owner_q)
                    || (outst_q == OUTST_W'(MAX_OUTSTANDING));
        stall       = local_stall || owner_stall || target_stall;

        owner_ack    = i_wb_cyc && owner_ack_raw && !err_q;
        accept_map   = i_wb_cyc && i_wb_stb && !stall && target != SLV_NONE;
        accept_unmap = i_wb_cyc && i_wb_stb && !stall && target == SLV_NONE;
        timeout_hit  = outst_q != '0 && !owner_ack
                    && timer_q == TIMER_W'(TIMEOUT - 1);

        o_wb_stall  = stall;
        o_wb_ack    = owner_ack;
        o_data      = owner_ack ? owner_rdata : '0;
        o_wb_err    = err_q;
        o_exception = err_q;

        o_s_addr = offset;
        o_s_data = i_data;
        o_s_we   = i_we;
        o_s_stb  = (i_wb_stb && !local_stall) ? sel : 3'b000;
        o_s_cyc[0] = i_wb_cyc && (owner_q == SLV_BOOTROM || sel[0]);
        o_s_cyc[1] = i_wb_cyc && (owner_q == SLV_RAM     || sel[1]);
        o_s_cyc[2] = i_wb_cyc && (owner_q == SLV_IO      || sel[2]);
    end

endmodule

// File: tb/tb_wb_interconnect.sv
// Directed self-checking bench for wb_interconnect: routing, pipelining,
// slave switching, unmapped error, timeout, abort and async reset.
module tb_wb_interconnect;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_wb_cyc, i_wb_stb, i_we;
    logic [31:0] i_addr, i_data;
    logic [31:0] o_data;
    logic        o_wb_stall, o_wb_ack, o_wb_err, o_exception;
    logic [31:0] o_s_addr, o_s_data;
    logic        o_s_we;
    logic [2:0]  o_s_cyc, o_s_stb;
    logic [2:0]  i_s_stall, i_s_ack;
    logic [95:0] i_s_data;

    int total = 0;
    int bad   = 0;

    wb_interconnect #(
        .TIMEOUT         (16),
        .MAX_OUTSTANDING (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_wb_cyc    (i_wb_cyc),
        .i_wb_stb    (i_wb_stb),
        .i_we        (i_we),
        .i_addr      (i_addr),
        .i_data      (i_data),
        .o_data      (o_data),
        .o_wb_stall  (o_wb_stall),
        .o_wb_ack    (o_wb_ack),
        .o_wb_err    (o_wb_err),
        .o_exception (o_exception),
        .o_s_addr    (o_s_addr),
        .o_s_data    (o_s_data),
        .o_s_we      (o_s_we),
        .o_s_cyc     (o_s_cyc),
        .o_s_stb     (o_s_stb),
        .i_s_stall   (i_s_stall),
        .i_s_ack     (i_s_ack),
        .i_s_data    (i_s_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        i_wb_cyc  = 1'b0;
        i_wb_stb  = 1'b0;
        i_we      = 1'b0;
        i_addr    = '0;
        i_data    = '0;
        i_s_stall = '0;
        i_s_ack   = '0;
        i_s_data  = {32'hcafe_0010, 32'h1111_0000, 32'hdead_beef};
        tick();
        tick();
        #1;
        chk("rst_ack",   32'(o_wb_ack), 0);
        chk("rst_err",   32'(o_wb_err), 0);
        chk("rst_exc",   32'(o_exception), 0);
        chk("rst_data",  o_data, 0);
        chk("rst_outst", 32'(dut.outst_q), 0);
        chk("rst_owner", 32'(dut.owner_q), 3);
        reset = 1'b0;
        tick();

        // Single read from bootrom, acked one cycle later
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        i_addr   = 32'hb000_0004;
        #1;
        chk("t1_stb",   32'(o_s_stb), 32'b001);
        chk("t1_cyc",   32'(o_s_cyc), 32'b001);
        chk("t1_addr",  o_s_addr, 32'h4);
        chk("t1_stall", 32'(o_wb_stall), 0);
        tick();
        i_wb_stb = 1'b0;
        i_s_ack  = 3'b001;
        #1;
        chk("t1_ack",   32'(o_wb_ack), 1);
        chk("t1_data",  o_data, 32'hdead_beef);
        chk("t1_out1",  32'(dut.outst_q), 1);
        tick();
        i_s_ack = 3'b000;
        #1;
        chk("t1_out0",  32'(dut.outst_q), 0);
        chk("t1_own",   32'(dut.owner_q), 3);
        chk("t1_noack", 32'(o_wb_ack), 0);
        chk("t1_data0", o_data, 0);

        // Three pipelined RAM requests, fourth stalls at the limit
        i_wb_stb = 1'b1;
        i_addr   = 32'hb000_8000;
        tick();
        i_addr = 32'hb000_8004;
        #1;
        chk("t2_stall1", 32'(o_wb_stall), 0);
        tick();
        i_addr = 32'hb000_8008;
        tick();
        chk("t2_out3",  32'(dut.outst_q), 3);
        chk("t2_own",   32'(dut.owner_q), 1);
        i_addr = 32'hb000_800c;
        #1;
        chk("t2_stall4", 32'(o_wb_stall), 1);
        chk("t2_nostb",  32'(o_s_stb), 0);
        i_s_ack = 3'b010;
        #1;
        chk("t2_ack1",   32'(o_wb_ack), 1);
        chk("t2_data1",  o_data, 32'h1111_0000);
        chk("t2_stallk", 32'(o_wb_stall), 1);
        tick();
        chk("t2_out2",   32'(dut.outst_q), 2);
        chk("t2_stall0", 32'(o_wb_stall), 0);
        chk("t2_ack2",   32'(o_wb_ack), 1);
        tick();
        chk("t2_out2b",  32'(dut.outst_q), 2);
        i_wb_stb = 1'b0;
        tick();
        chk("t2_out1",   32'(dut.outst_q), 1);
        chk("t2_own1",   32'(dut.owner_q), 1);
        tick();
        chk("t2_out0",   32'(dut.outst_q), 0);
        chk("t2_own0",   32'(dut.owner_q), 3);
        i_s_ack = 3'b000;

        // Switch from bootrom to IO waits for the bootrom ack
        i_wb_stb = 1'b1;
        i_addr   = 32'hb000_0000;
        tick();
        i_addr = 32'hc000_0010;
        #1;
        chk("t3_stall",  32'(o_wb_stall), 1);
        chk("t3_nostb",  32'(o_s_stb), 0);
        chk("t3_cyc",    32'(o_s_cyc), 32'b101);
        tick();
        chk("t3_out1",   32'(dut.outst_q), 1);
        i_s_ack = 3'b001;
        #1;
        chk("t3_ack0",   32'(o_wb_ack), 1);
        chk("t3_stallk", 32'(o_wb_stall), 1);
        tick();
        i_s_ack = 3'b000;
        #1;
        chk("t3_stall0", 32'(o_wb_stall), 0);
        chk("t3_stb2",   32'(o_s_stb), 32'b100);
        chk("t3_addr",   o_s_addr, 32'h10);
        tick();
        chk("t3_own2",   32'(dut.owner_q), 2);
        i_wb_stb = 1'b0;
        i_s_ack  = 3'b100;
        #1;
        chk("t3_ack2",   32'(o_wb_ack), 1);
        chk("t3_data2",  o_data, 32'hcafe_0010);
        tick();
        i_s_ack = 3'b000;
        chk("t3_out0",   32'(dut.outst_q), 0);

        // Unmapped read
        i_wb_stb = 1'b1;
        i_addr   = 32'ha000_0000;
        #1;
        chk("t4_nostb",  32'(o_s_stb), 0);
        chk("t4_stall",  32'(o_wb_stall), 0);
        chk("t4_err0",   32'(o_wb_err), 0);
        tick();
        i_wb_stb = 1'b0;
        #1;
        chk("t4_err1",   32'(o_wb_err), 1);
        chk("t4_exc1",   32'(o_exception), 1);
        chk("t4_noack",  32'(o_wb_ack), 0);
        tick();
        chk("t4_err2",   32'(o_wb_err), 0);
        chk("t4_exc2",   32'(o_exception), 0);
        chk("t4_out0",   32'(dut.outst_q), 0);

        // IO write that is never acked times out
        i_wb_stb = 1'b1;
        i_we     = 1'b1;
        i_addr   = 32'hc000_0000;
        i_data   = 32'h1234_5678;
        #1;
        chk("t5_we",    32'(o_s_we), 1);
        chk("t5_wdata", o_s_data, 32'h1234_5678);
        chk("t5_stb",   32'(o_s_stb), 32'b100);
        tick();
        i_wb_stb = 1'b0;
        i_we     = 1'b0;
        chk("t5_err_e0", 32'(o_wb_err), 0);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("t5_err_wait", 32'(o_wb_err), 0);
        end
        tick();
        chk("t5_err",   32'(o_wb_err), 1);
        chk("t5_exc",   32'(o_exception), 1);
        chk("t5_out0",  32'(dut.outst_q), 0);
        chk("t5_own",   32'(dut.owner_q), 3);
        i_s_ack = 3'b100;
        #1;
        chk("t5_lateack",  32'(o_wb_ack), 0);
        tick();
        chk("t5_errend",   32'(o_wb_err), 0);
        chk("t5_lateack2", 32'(o_wb_ack), 0);
        i_s_ack = 3'b000;

        // Abort by dropping cyc, then async reset mid-transfer
        i_wb_stb = 1'b1;
        i_addr   = 32'hb000_8000;
        tick();
        i_addr = 32'hb000_8004;
        tick();
        chk("t6_out2",  32'(dut.outst_q), 2);
        i_wb_stb = 1'b0;
        i_wb_cyc = 1'b0;
        i_s_ack  = 3'b010;
        #1;
        chk("t6_cyc0",  32'(o_s_cyc), 0);
        chk("t6_noack", 32'(o_wb_ack), 0);
        tick();
        chk("t6_out0",  32'(dut.outst_q), 0);
        chk("t6_own",   32'(dut.owner_q), 3);
        chk("t6_noerr", 32'(o_wb_err), 0);
        chk("t6_late",  32'(o_wb_ack), 0);
        i_s_ack  = 3'b000;
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        i_addr   = 32'hb000_8000;
        tick();
        chk("t6_out1",  32'(dut.outst_q), 1);
        i_wb_stb = 1'b0;
        i_s_ack  = 3'b010;
        reset    = 1'b1;
        #1;
        chk("t6_rst_out",  32'(dut.outst_q), 0);
        chk("t6_rst_own",  32'(dut.owner_q), 3);
        chk("t6_rst_ack",  32'(o_wb_ack), 0);
        chk("t6_rst_data", o_data, 0);
        chk("t6_rst_err",  32'(o_wb_err), 0);
        tick();
        chk("t6_rst_ack2", 32'(o_wb_ack), 0);
        chk("t6_rst_exc",  32'(o_exception), 0);
        reset    = 1'b0;
        i_s_ack  = 3'b000;
        i_wb_cyc = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
